aes_inv_cipher_iter: RTL and testbench
======================================

AES_INV_CIPHER_ITER -- requirements
Module: aes_inv_cipher_iter

Interface
REQ-001 SHALL have parameter nk, default 8, meaning key length in 32-bit words (4, 6 or 8).
REQ-002 SHALL have parameter nr, default 14, meaning the number of rounds (10, 12 or 14, matching nk).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: request to decrypt cipher_in; sampled only in IDLE.
REQ-006 SHALL have port cipher_in, input, 128 bits: ciphertext block, byte 0 at the MSBs.
REQ-007 SHALL have port key_schedule, input, 128*(nr+1) bits: expanded key with round key 0 in the most significant 128 bits, round key nr in the least significant.
REQ-008 SHALL have port plain_out, output, 128 bits: the recovered plaintext block, byte 0 at the MSBs.
REQ-009 SHALL have port busy, output, 1 bit: high while a block is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse marking plain_out valid.

Function
REQ-011 SHALL implement a state machine with states IDLE, ROUND, FINAL and DONE.
REQ-012 SHALL, in IDLE with start=1, load state = cipher_in XOR rk[nr], set the round counter to nr-1, and go to ROUND.
REQ-013 SHALL, in ROUND, on each edge apply state = InvMixColumns(InvSubBytes(InvShiftRows(state)) XOR rk[counter]).
REQ-014 SHALL, in ROUND, decrement the counter on each edge and go to FINAL after applying round 1.
REQ-015 SHALL, in FINAL, apply state = InvSubBytes(InvShiftRows(state)) XOR rk[0] with no InvMixColumns, copy the result to plain_out, and go to DONE.
REQ-016 SHALL, in DONE, hold done=1 for exactly one cycle and then return to IDLE.
REQ-017 SHALL assert busy in ROUND and FINAL and deassert it in IDLE and DONE.
REQ-018 SHALL produce the done pulse nr+1 cycles after the edge that sampled start; for nr=14, done is high in cycle 15.
REQ-019 SHALL ignore start while not in IDLE; this includes the DONE cycle, and no queuing is allowed.
REQ-020 SHALL hold plain_out unchanged from FINAL until the next FINAL.
REQ-021 SHALL perform all GF(2^8) arithmetic with modulus x^8+x^4+x^3+x+1, using the InvMixColumns coefficients 0e, 0b, 0d, 09.
REQ-022 SHALL read key_schedule combinationally each round; the driver keeps key_schedule stable while busy=1, and the block does not capture it.

Reset
REQ-023 SHALL, when rst=1 at a rising edge, go to IDLE and clear plain_out, the internal state and the counter to 0, with busy=0 and done=0.
REQ-024 SHALL give rst priority over start and over any in-flight round; on reset mid-operation the block abandons the block and emits no done pulse.
REQ-025 SHALL accept start in the first cycle after rst deasserts.

Structure
REQ-026 SHALL place the following in shared package aes_pkg: the FSM state type; the constants NB=4 and the GF modulus 8'h1B; and functions for xtime, InvShiftRows and InvMixColumns.
REQ-027 SHALL instantiate 16 copies of sub-module aes_inv_sbox (8-bit in, 8-bit out, combinational lookup table) for InvSubBytes.
REQ-028 SHALL use exactly one round datapath, reused every cycle; the rounds are not unrolled.

Verification
REQ-029 SHALL cover this scenario: nk=8, nr=14, key 000102...1f, cipher_in 8ea2b7ca516745bfeafc49904b496089, start pulse -> done in cycle 15, plain_out 00112233445566778899aabbccddeeff.
REQ-030 SHALL cover this scenario: nk=4, nr=10, key 000102...0f, cipher_in 69c4e0d86a7b0430d8cdb78070b4c55a -> done in cycle 11, same plaintext as REQ-029.
REQ-031 SHALL cover this scenario: nk=6, nr=12, key 000102...17, cipher_in dda97ca4864cdfe06eaf70a0ec0d7191 -> done in cycle 13, same plaintext as REQ-029.
REQ-032 SHALL cover this scenario: start held high continuously with a second cipher_in changed mid-operation -> exactly one done per nr+2 cycles, each result matching the cipher_in sampled in IDLE.
REQ-033 SHALL cover this scenario: rst asserted in round 5 -> next cycle busy=0, done=0, plain_out=0, no done pulse appears; a new start then completes correctly.
REQ-034 SHALL cover this scenario: back-to-back blocks with start high in the DONE cycle -> start ignored; start accepted in the following IDLE cycle.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM state type, constants and the inverse-cipher
// linear layers (InvShiftRows, InvMixColumns) built on GF(2^8) helpers.
package aes_pkg;

  localparam int NB = 4;
  localparam logic [7:0] GF_MOD = 8'h1B;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_MOD : 8'h00);
  endfunction

  // Multiply by a 4-bit constant; enough for the 0e/0b/0d/09 coefficients.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 4; i++) begin
      p = c[i] ? (p ^ x) : p;
      x = xtime(x);
    end
    return p;
  endfunction

  // Byte i = row + 4*col sits at bits [127-8i -: 8]; row r rotates right by r.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = 128'h0;
    for (int c = 0; c < NB; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9);
      o[119-32*c -: 8] = gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd);
      o[111-32*c -: 8] = gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb);
      o[103-32*c -: 8] = gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// AES inverse S-box as a combinational 256-entry lookup table.
module aes_inv_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Entry 0 occupies the most significant byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // 255 - in_byte equals ~in_byte, so the bit offset is {~in_byte, 3'b000}.
  assign out_byte = INV_SBOX[{~in_byte, 3'b000} +: 8];

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one shared round datapath, one round per clock,
// done pulse nr+1 cycles after start is sampled.
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int nk = 8,
  parameter int nr = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [127:0]          cipher_in,
  input  logic [128*(nr+1)-1:0] key_schedule,
  output logic [127:0]          plain_out,
  output logic                  busy,
  output logic                  done
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(nr - 1);
  // A key length inconsistent with the round count never starts a block.
  localparam logic CFG_OK = (nr == nk + 6) ? 1'b1 : 1'b0;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [127:0]     st_r, st_s;
  logic [127:0]     plain_r, plain_s;
  logic             busy_r, done_r;
  logic [127:0]     rk_s, sr_s, sb_s, ark_s, mix_s;

  // Round key cnt_r lives 128*(nr-cnt_r) bits up from the LSB end.
  assign rk_s  = key_schedule[128*(nr - int'(cnt_r)) +: 128];
  assign sr_s  = inv_shift_rows(st_r);
  assign ark_s = sb_s ^ rk_s;
  assign mix_s = inv_mix_columns(ark_s);

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_inv_sbox u_sbox (
      .in_byte  (sr_s[127-8*i -: 8]),
      .out_byte (sb_s[127-8*i -: 8])
    );
  end

  // Next-state and datapath selection for the round FSM.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    st_s    = st_r;
    plain_s = plain_r;
    case (state_r)
      IDLE: begin
        if (start && CFG_OK) begin
          st_s    = cipher_in ^ key_schedule[127:0];
          cnt_s   = CNT_INIT;
          state_s = ROUND;
        end else begin
          state_s = IDLE;
        end
      end
      ROUND: begin
        st_s  = mix_s;
        cnt_s = cnt_r - 4'd1;
        if (cnt_r == 4'd1) begin
          state_s = FINAL;
        end else begin
          state_s = ROUND;
        end
      end
      FINAL: begin
        st_s    = ark_s;
        plain_s = ark_s;
        state_s = DONE;
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      st_r    <= 128'h0;
      plain_r <= 128'h0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      st_r    <= st_s;
      plain_r <= plain_s;
      busy_r  <= (state_s == ROUND) || (state_s == FINAL);
      done_r  <= (state_s == DONE);
    end
  end

  assign plain_out = plain_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Scoreboard bench: three configurations (nr=14/10/12) driven with FIPS-197 vectors.
module tb_aes_inv_cipher_iter;

  typedef struct packed {
    logic [127:0] pt;
    int           cyc;
  } exp_t;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT14   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CT10   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT12   = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};

  logic clk = 1'b0;
  logic rst;
  logic start14, start10, start12;
  logic [127:0] ct14, ct10, ct12, p14, p10, p12;
  logic [1919:0] ks14;
  logic [1407:0] ks10;
  logic [1663:0] ks12;
  logic busy14, busy10, busy12, d14, d10, d12;

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;
  exp_t q14[$], q10[$], q12[$];
  logic [7:0] sb [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_inv_cipher_iter #(.nk(8), .nr(14)) dut14 (
    .clk(clk), .rst(rst), .start(start14), .cipher_in(ct14), .key_schedule(ks14),
    .plain_out(p14), .busy(busy14), .done(d14));
  aes_inv_cipher_iter #(.nk(4), .nr(10)) dut10 (
    .clk(clk), .rst(rst), .start(start10), .cipher_in(ct10), .key_schedule(ks10),
    .plain_out(p10), .busy(busy10), .done(d10));
  aes_inv_cipher_iter #(.nk(6), .nr(12)) dut12 (
    .clk(clk), .rst(rst), .start(start12), .cipher_in(ct12), .key_schedule(ks12),
    .plain_out(p12), .busy(busy12), .done(d12));

  task automatic check128(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // Driver-side FIPS-197 key expansion; w[0] lands in the top 32 bits.
  function automatic logic [1919:0] expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc;
    logic [1919:0] r;
    rc = 8'h01;
    r = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = tb_gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < 4*(nr+1); i++) r[1919-32*i -: 32] = w[i];
    return r;
  endfunction

  task automatic push(input int which, input logic [127:0] pt, input int c);
    exp_t e;
    e.pt = pt;
    e.cyc = c;
    if (which == 14) q14.push_back(e);
    else if (which == 10) q10.push_back(e);
    else q12.push_back(e);
  endtask

  task automatic drain(input string nm, input int bound);
    int n;
    n = 0;
    while ((q14.size() + q10.size() + q12.size()) != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check_int(nm, q14.size() + q10.size() + q12.size(), 0);
  endtask

  // Monitor: every done pulse must match the oldest expected block.
  exp_t m14, m10, m12;
  always @(negedge clk) begin
    if (d14 === 1'b1) begin
      check_int("n14_done_expected", int'(q14.size() != 0), 1);
      if (q14.size() != 0) begin
        m14 = q14.pop_front();
        check128("n14_plain", p14, m14.pt);
        check_int("n14_done_cycle", cyc, m14.cyc);
      end
    end
    if (d10 === 1'b1) begin
      check_int("n10_done_expected", int'(q10.size() != 0), 1);
      if (q10.size() != 0) begin
        m10 = q10.pop_front();
        check128("n10_plain", p10, m10.pt);
        check_int("n10_done_cycle", cyc, m10.cyc);
      end
    end
    if (d12 === 1'b1) begin
      check_int("n12_done_expected", int'(q12.size() != 0), 1);
      if (q12.size() != 0) begin
        m12 = q12.pop_front();
        check128("n12_plain", p12, m12.pt);
        check_int("n12_done_cycle", cyc, m12.cyc);
      end
    end
  end

  logic [1919:0] full;
  logic [127:0] c_ct [3];
  logic [127:0] c_pt [3];
  logic [1407:0] c_ks [3];
  int n;

  initial begin
    // Forward S-box from GF inverse plus affine map, for the key expansion only.
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (tb_gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    ks14 = expand(KEY256, 8, 14);
    full = expand(KEY128, 4, 10);
    ks10 = full[1919 -: 1408];
    full = expand(KEY192, 6, 12);
    ks12 = full[1919 -: 1664];
    rst = 1'b1;
    start14 = 1'b0; start10 = 1'b0; start12 = 1'b0;
    ct14 = CT14; ct10 = CT10; ct12 = CT12;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_int("rst_busy14", busy14, 0);
    check_int("rst_done14", d14, 0);
    check128("rst_plain14", p14, 128'h0);
    check_int("rst_busy10", busy10, 0);
    check128("rst_plain12", p12, 128'h0);

    // All three key sizes, start raised in the first cycle out of reset
    rst = 1'b0;
    start14 = 1'b1; start10 = 1'b1; start12 = 1'b1;
    @(negedge clk);
    push(14, PT, cyc + 14);
    push(10, PT, cyc + 10);
    push(12, PT, cyc + 12);
    check_int("busy14_after_start", busy14, 1);
    check_int("busy10_after_start", busy10, 1);
    check_int("busy12_after_start", busy12, 1);
    start14 = 1'b0; start10 = 1'b0; start12 = 1'b0;
    drain("drain_three_sizes", 40);
    repeat (2) @(negedge clk);

    // Back-to-back: start high in the DONE cycle is ignored
    start14 = 1'b1;
    @(negedge clk);
    push(14, PT, cyc + 14);
    start14 = 1'b0;
    n = 0;
    while (d14 !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_int("b2b_done_seen", int'(d14), 1);
    start14 = 1'b1;
    @(negedge clk);
    check_int("b2b_idle_after_done", busy14, 0);
    @(negedge clk);
    push(14, PT, cyc + 14);
    check_int("b2b_second_accepted", busy14, 1);
    start14 = 1'b0;
    repeat (5) @(negedge clk);
    check128("plain_held_mid_block", p14, PT);
    drain("drain_b2b", 40);
    repeat (2) @(negedge clk);

    // Start held high on nr=10, cipher_in disturbed mid-block, key swapped while idle
    c_ct[0] = CT10; c_pt[0] = PT;   c_ks[0] = ks10;
    full = expand(KEY_B, 4, 10);
    c_ct[1] = CT_B; c_pt[1] = PT_B; c_ks[1] = full[1919 -: 1408];
    c_ct[2] = CT_B; c_pt[2] = PT_B; c_ks[2] = full[1919 -: 1408];
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      ct10 = c_ct[b];
      ks10 = c_ks[b];
      start10 = 1'b1;
      @(negedge clk);
      push(10, c_pt[b], cyc + 10);
      ct10 = 128'hffffffffffffffffffffffffffffffff;
      repeat (10) @(negedge clk);
    end
    start10 = 1'b0;
    drain("drain_held_start", 40);
    repeat (2) @(negedge clk);

    // Reset in round 5 abandons the block; a fresh start then completes
    start14 = 1'b1;
    @(negedge clk);
    start14 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_int("midrst_busy", busy14, 0);
    check_int("midrst_done", d14, 0);
    check128("midrst_plain", p14, 128'h0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    start14 = 1'b1;
    @(negedge clk);
    push(14, PT, cyc + 14);
    start14 = 1'b0;
    drain("drain_after_rst", 40);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
